ntt_core_wmm_clbu_pp_tag_gen: RTL and testbench

//  Upstream stimulus stage of the NTT-core-with-matrix-multiplication CLBU+PP model bench.
//  It emits PSI*R tagged coefficients per cycle into the CLBU+PP input.

---
 rtl/ntt_core_wmm_clbu_pp_tag_gen_if.sv | 33 +++
 rtl/ntt_core_wmm_clbu_pp_tag_gen.sv | 174 +++++++++++++++++
 tb/tb_ntt_core_wmm_clbu_pp_tag_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_core_wmm_clbu_pp_tag_gen_if.sv
// Command and tagged-coefficient bus of the CLBU+PP tag generator.
interface ntt_core_wmm_clbu_pp_tag_gen_if #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned MOD_NTT_W = 64,
    parameter int unsigned BPBS_ID_W = 4
);
    logic                         cmd_vld;
    logic                         cmd_rdy;
    logic [15:0]                  cmd_batch_start;
    logic [15:0]                  cmd_batch_nb;
    logic [BPBS_ID_W:0]           cmd_pbs_nb;
    logic                         gen_en;
    logic [LANES*MOD_NTT_W-1:0]   out_data;
    logic                         out_avail;
    logic                         out_sob;
    logic                         out_eob;
    logic                         out_sol;
    logic                         out_eol;
    logic                         busy;
    logic                         done;

    // Stimulus side: issues commands and enables, observes the stream.
    modport master (
        output cmd_vld, cmd_batch_start, cmd_batch_nb, cmd_pbs_nb, gen_en,
        input  cmd_rdy, out_data, out_avail, out_sob, out_eob, out_sol, out_eol, busy, done
    );

    // Generator side.
    modport slave (
        input  cmd_vld, cmd_batch_start, cmd_batch_nb, cmd_pbs_nb, gen_en,
        output cmd_rdy, out_data, out_avail, out_sob, out_eob, out_sol, out_eol, busy, done
    );
endinterface

// File: rtl/ntt_core_wmm_clbu_pp_tag_gen.sv
// Tagged-coefficient generator feeding the CLBU+PP input: every lane carries
// {val, batch_id, pbs_id, stg_iter} so the downstream checker can trace it.
module ntt_core_wmm_clbu_pp_tag_gen #(
    parameter int unsigned R           = 2,
    parameter int unsigned PSI         = 8,
    parameter int unsigned BPBS_NB     = 16,
    parameter int unsigned STG_ITER_NB = 8,
    parameter int unsigned MOD_NTT_W   = 64
) (
    input logic                              clk,
    input logic                              s_rst,
    ntt_core_wmm_clbu_pp_tag_gen_if.slave    bus
);
    localparam int unsigned LANES       = PSI * R;
    localparam int unsigned BPBS_ID_W   = $clog2(BPBS_NB);
    localparam int unsigned STG_ITER_W  = $clog2(STG_ITER_NB);
    localparam int unsigned BATCH_NB_W  = 16;
    localparam int unsigned VAL_W       = MOD_NTT_W - BATCH_NB_W - BPBS_ID_W - STG_ITER_W;
    localparam int unsigned PBS_NB_W    = BPBS_ID_W + 1;
    localparam int unsigned DATA_W      = LANES * MOD_NTT_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e                  state_q, state_d;
    logic [BATCH_NB_W-1:0]   batch_start_q, batch_start_d;
    logic [BATCH_NB_W-1:0]   batch_nb_q, batch_nb_d;
    logic [BPBS_ID_W-1:0]    pbs_last_q, pbs_last_d;
    logic [BPBS_ID_W-1:0]    pbs_q, pbs_d;
    logic [STG_ITER_W-1:0]   stg_q, stg_d;
    logic [BATCH_NB_W-1:0]   batch_q, batch_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    avail_q, avail_d;
    logic                    sob_q, sob_d;
    logic                    eob_q, eob_d;
    logic                    sol_q, sol_d;
    logic                    eol_q, eol_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cmd_rdy_q, cmd_rdy_d;

    logic [BATCH_NB_W-1:0]   batch_id;
    logic                    pbs_wrap;
    logic                    stg_wrap;
    logic                    last_word;

    // Next-state, counter advance and registered-output computation.
    always_comb begin
        state_d       = state_q;
        batch_start_d = batch_start_q;
        batch_nb_d    = batch_nb_q;
        pbs_last_d    = pbs_last_q;
        pbs_d         = pbs_q;
        stg_d         = stg_q;
        batch_d       = batch_q;
        data_d        = data_q;
        avail_d       = 1'b0;
        sob_d         = 1'b0;
        eob_d         = 1'b0;
        sol_d         = 1'b0;
        eol_d         = 1'b0;

        batch_id  = batch_start_q + batch_q;
        pbs_wrap  = (pbs_q == pbs_last_q);
        stg_wrap  = (stg_q == STG_ITER_W'(STG_ITER_NB - 1));
        last_word = pbs_wrap && stg_wrap && (batch_q == batch_nb_q - 16'd1);

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_vld && cmd_rdy_q) begin
                    batch_start_d = bus.cmd_batch_start;
                    batch_nb_d    = bus.cmd_batch_nb;
                    // pbs_nb is clamped to [1,BPBS_NB]; keep it as the last pbs_id.
                    if (bus.cmd_pbs_nb == '0) begin
                        pbs_last_d = '0;
                    end else if (bus.cmd_pbs_nb > PBS_NB_W'(BPBS_NB)) begin
                        pbs_last_d = BPBS_ID_W'(BPBS_NB - 1);
                    end else begin
                        pbs_last_d = BPBS_ID_W'(bus.cmd_pbs_nb - PBS_NB_W'(1));
                    end
                    pbs_d   = '0;
                    stg_d   = '0;
                    batch_d = '0;
                    state_d = (bus.cmd_batch_nb != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (bus.gen_en) begin
                    avail_d = 1'b1;
                    sol_d   = (pbs_q == '0);
                    eol_d   = pbs_wrap;
                    sob_d   = (pbs_q == '0) && (stg_q == '0);
                    eob_d   = pbs_wrap && stg_wrap;
                    for (int unsigned l = 0; l < LANES; l++) begin
                        data_d[l*MOD_NTT_W +: MOD_NTT_W] = {VAL_W'(l), batch_id, pbs_q, stg_q};
                    end
                    // pbs_id innermost, then stg_iter, then batch.
                    if (pbs_wrap) begin
                        pbs_d = '0;
                        if (stg_wrap) begin
                            stg_d   = '0;
                            batch_d = batch_q + 16'd1;
                        end else begin
                            stg_d = stg_q + STG_ITER_W'(1);
                        end
                    end else begin
                        pbs_d = pbs_q + BPBS_ID_W'(1);
                    end
                    if (last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_rdy_d = (state_d == ST_IDLE);
        busy_d    = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State, counters and output registers; reset aborts any command.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q       <= ST_IDLE;
            batch_start_q <= '0;
            batch_nb_q    <= '0;
            pbs_last_q    <= '0;
            pbs_q         <= '0;
            stg_q         <= '0;
            batch_q       <= '0;
            data_q        <= '0;
            avail_q       <= 1'b0;
            sob_q         <= 1'b0;
            eob_q         <= 1'b0;
            sol_q         <= 1'b0;
            eol_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_rdy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            batch_start_q <= batch_start_d;
            batch_nb_q    <= batch_nb_d;
            pbs_last_q    <= pbs_last_d;
            pbs_q         <= pbs_d;
            stg_q         <= stg_d;
            batch_q       <= batch_d;
            data_q        <= data_d;
            avail_q       <= avail_d;
            sob_q         <= sob_d;
            eob_q         <= eob_d;
            sol_q         <= sol_d;
            eol_q         <= eol_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cmd_rdy_q     <= cmd_rdy_d;
        end
    end

    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.out_data  = data_q;
    assign bus.out_avail = avail_q;
    assign bus.out_sob   = sob_q;
    assign bus.out_eob   = eob_q;
    assign bus.out_sol   = sol_q;
    assign bus.out_eol   = eol_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ntt_core_wmm_clbu_pp_tag_gen.sv
// Bench for the CLBU+PP tag generator: commands checked against a nested-loop
// reference of the expected coefficient stream.
module tb_ntt_core_wmm_clbu_pp_tag_gen;
    localparam int LANES  = 16;
    localparam int W      = 64;
    localparam int STG_NB = 8;

    typedef struct {
        int bid;
        int pbs;
        int stg;
        bit sob;
        bit eob;
        bit sol;
        bit eol;
    } exp_t;

    logic clk = 1'b0;
    logic s_rst;
    int   checks = 0;
    int   errors = 0;
    logic [LANES*W-1:0] exp_bus;

    ntt_core_wmm_clbu_pp_tag_gen_if #(.LANES(LANES), .MOD_NTT_W(W), .BPBS_ID_W(4)) bus ();

    ntt_core_wmm_clbu_pp_tag_gen dut (
        .clk   (clk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*W-1:0] make_bus(input exp_t e);
        logic [LANES*W-1:0] b;
        for (int l = 0; l < LANES; l++) begin
            b[l*W +: W] = {41'(l), 16'(e.bid), 4'(e.pbs), 3'(e.stg)};
        end
        return b;
    endfunction

    task automatic test_reset();
        s_rst = 1'b1;
        bus.cmd_vld = 1'b0; bus.gen_en = 1'b0;
        bus.cmd_batch_start = '0; bus.cmd_batch_nb = '0; bus.cmd_pbs_nb = '0;
        repeat (2) @(negedge clk);
        exp_bus = '0;
        checks++;
        if ({bus.cmd_rdy, bus.out_avail, bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol,
             bus.busy, bus.done} !== 8'h00 || bus.out_data !== exp_bus) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b avail=%b busy=%b done=%b data_nz=%b, required all 0",
                     bus.cmd_rdy, bus.out_avail, bus.busy, bus.done, |bus.out_data);
        end
        s_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: rdy=%b busy=%b done=%b, required 1 0 0", bus.cmd_rdy, bus.busy, bus.done);
        end
    endtask

    // Issues one command and checks the whole emitted stream against the model.
    // mode: 0 gen_en always 1, 1 toggle 1,0,.., 2 random.
    task automatic run_cmd(input logic [15:0] start, input logic [15:0] bnb, input logic [4:0] pnb,
                           input int mode, input bit hold_vld);
        exp_t q[$];
        exp_t e;
        int   pl, budget, cyc;
        bit   g, finished, exp_last;
        int   waitc;

        pl = (pnb == 0) ? 1 : ((pnb > 16) ? 16 : int'(pnb));
        for (int b = 0; b < int'(bnb); b++)
            for (int s = 0; s < STG_NB; s++)
                for (int p = 0; p < pl; p++) begin
                    e.bid = (int'(start) + b) % 65536;
                    e.pbs = p; e.stg = s;
                    e.sol = (p == 0); e.eol = (p == pl - 1);
                    e.sob = (p == 0) && (s == 0); e.eob = (p == pl - 1) && (s == STG_NB - 1);
                    q.push_back(e);
                end

        waitc = 0;
        while (bus.cmd_rdy !== 1'b1 && waitc < 10) begin
            @(negedge clk); waitc++;
        end
        checks++;
        if (bus.cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_rdy_wait: rdy=%b after %0d cycles, required 1", bus.cmd_rdy, waitc);
        end
        bus.cmd_vld = 1'b1; bus.cmd_batch_start = start; bus.cmd_batch_nb = bnb; bus.cmd_pbs_nb = pnb;
        bus.gen_en = 1'b0;
        @(negedge clk);
        if (!hold_vld) bus.cmd_vld = 1'b0;
        bus.cmd_batch_start = 16'($urandom); bus.cmd_batch_nb = 16'($urandom); bus.cmd_pbs_nb = 5'($urandom);

        checks++;
        if (bnb == 0) begin
            if (bus.done !== 1'b1 || bus.out_avail !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
                errors++;
                $display("FAIL empty_done: done=%b avail=%b busy=%b rdy=%b, required 1 0 0 0",
                         bus.done, bus.out_avail, bus.busy, bus.cmd_rdy);
            end
        end else begin
            if (bus.busy !== 1'b1 || bus.cmd_rdy !== 1'b0 || bus.done !== 1'b0 || bus.out_avail !== 1'b0) begin
                errors++;
                $display("FAIL accept_state: busy=%b rdy=%b done=%b avail=%b, required 1 0 0 0",
                         bus.busy, bus.cmd_rdy, bus.done, bus.out_avail);
            end
            budget   = 2 * q.size() + 20;
            cyc      = 0;
            finished = 0;
            while (!finished && cyc < budget) begin
                g = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                bus.gen_en = g;
                @(negedge clk);
                cyc++;
                checks++;
                if (bus.out_avail !== (g && q.size() > 0)) begin
                    errors++;
                    $display("FAIL avail: cycle %0d avail=%b, required %b", cyc, bus.out_avail, g && q.size() > 0);
                end
                exp_last = 0;
                if (bus.out_avail === 1'b1 && q.size() > 0) begin
                    e = q.pop_front();
                    exp_bus = make_bus(e);
                    exp_last = (q.size() == 0);
                    checks++;
                    if (bus.out_data !== exp_bus) begin
                        errors++;
                        $display("FAIL word_data: lane0=%h lane5=%h, required lane0=%h lane5=%h",
                                 bus.out_data[0 +: W], bus.out_data[5*W +: W], exp_bus[0 +: W], exp_bus[5*W +: W]);
                    end
                    checks++;
                    if ({bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol} !== {e.sob, e.eob, e.sol, e.eol}) begin
                        errors++;
                        $display("FAIL word_flags: sob/eob/sol/eol=%b%b%b%b, required %b%b%b%b (bid=%0d pbs=%0d stg=%0d)",
                                 bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol,
                                 e.sob, e.eob, e.sol, e.eol, e.bid, e.pbs, e.stg);
                    end
                end else begin
                    checks++;
                    if (bus.out_data !== exp_bus ||
                        {bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol} !== 4'b0000) begin
                        errors++;
                        $display("FAIL bubble_hold: data_held=%b flags=%b%b%b%b, required held and 0000",
                                 bus.out_data === exp_bus, bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol);
                    end
                end
                checks++;
                if (bus.done !== exp_last || bus.busy !== (q.size() > 0 && !exp_last)) begin
                    errors++;
                    $display("FAIL done_busy: done=%b busy=%b, required %b %b (left=%0d)",
                             bus.done, bus.busy, exp_last, q.size() > 0, q.size());
                end
                finished = exp_last || (bus.done === 1'b1);
            end
            checks++;
            if (!finished || q.size() != 0) begin
                errors++;
                $display("FAIL stream_end: finished=%b words_left=%0d, required 1 0", finished, q.size());
            end
        end
        bus.gen_en  = 1'b0;
        bus.cmd_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.done !== 1'b0 || bus.out_avail !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL back_idle: rdy=%b done=%b avail=%b busy=%b, required 1 0 0 0",
                     bus.cmd_rdy, bus.done, bus.out_avail, bus.busy);
        end
    endtask

    task automatic test_basic();
        run_cmd(16'h0000, 16'd1, 5'd2, 0, 1'b0);
    endtask

    task automatic test_bubbles();
        run_cmd(16'h0000, 16'd1, 5'd2, 1, 1'b0);
    endtask

    task automatic test_wrap();
        run_cmd(16'hFFFE, 16'd3, 5'd1, 0, 1'b0);
    endtask

    task automatic test_clamp_empty();
        run_cmd(16'h1234, 16'd1, 5'd0, 0, 1'b0);
        run_cmd(16'h0042, 16'd1, 5'd31, 2, 1'b0);
        run_cmd(16'h0007, 16'd0, 5'd4, 0, 1'b0);
    endtask

    task automatic test_abort();
        int seen = 0;
        int cyc = 0;
        bus.cmd_vld = 1'b1; bus.cmd_batch_start = 16'h0000; bus.cmd_batch_nb = 16'd1; bus.cmd_pbs_nb = 5'd2;
        bus.gen_en = 1'b1;
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        while (seen < 6 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (bus.out_avail === 1'b1) seen++;
        end
        checks++;
        if (seen != 6) begin
            errors++;
            $display("FAIL abort_reach: words seen=%0d, required 6", seen);
        end
        s_rst = 1'b1;
        @(negedge clk);
        exp_bus = '0;
        checks++;
        if ({bus.cmd_rdy, bus.out_avail, bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol,
             bus.busy, bus.done} !== 8'h00 || bus.out_data !== exp_bus) begin
            errors++;
            $display("FAIL abort_outputs: rdy=%b avail=%b busy=%b done=%b data_nz=%b, required all 0",
                     bus.cmd_rdy, bus.out_avail, bus.busy, bus.done, |bus.out_data);
        end
        s_rst = 1'b0;
        bus.gen_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.done !== 1'b0 || bus.out_avail !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: rdy=%b done=%b avail=%b, required 1 0 0", bus.cmd_rdy, bus.done, bus.out_avail);
        end
        run_cmd(16'h0000, 16'd1, 5'd2, 0, 1'b0);
    endtask

    task automatic test_busy();
        run_cmd(16'h00A0, 16'd2, 5'd3, 2, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_cmd(16'($urandom), 16'($urandom_range(1, 3)), 5'($urandom_range(0, 31)), 2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_wrap();
        test_clamp_empty();
        test_abort();
        test_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
